// File: rtl/iaoq_sequencer_pkg.sv
// Shared definitions for the IAOQ sequencer: state encoding, default reset
// vector, instruction size and the word-alignment helper.
package iaoq_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_PEND = 2'b10
   } state_e;

   localparam int unsigned IAOQ_INSTR_BYTES  = 4;
   localparam logic [31:0] IAOQ_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] ADDR_ALIGN_MASK   = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_addr(input logic [31:0] addr);
      return addr & ADDR_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/iaoq_redirect_buf.sv
// Single-entry buffer for a taken branch that resolved while the queue was
// stalled; holds the target and the delay-slot nullify flag until applied.
module iaoq_redirect_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] target_i,
   input  logic        nullify_i,
   output logic        pend_valid_o,
   output logic [31:0] pend_target_o,
   output logic        pend_nullify_o
);

   logic        valid_q;
   logic [31:0] target_q;
   logic        nullify_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         target_q  <= '0;
         nullify_q <= 1'b0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q   <= 1'b1;
         target_q  <= target_i;
         nullify_q <= nullify_i;
      end
   end

   assign pend_valid_o   = valid_q;
   assign pend_target_o  = target_q;
   assign pend_nullify_o = nullify_q;

endmodule

// File: rtl/iaoq_sequencer.sv
// IAOQ front/back controller: chooses load enables and next values for the two
// PC queue registers (boot, sequential advance, delayed branch, stall, trap).
module iaoq_sequencer
   import iaoq_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = IAOQ_RESET_VECTOR,
   parameter int unsigned INSTR_BYTES  = IAOQ_INSTR_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        br_nullify,
   input  logic        trap_valid,
   input  logic [31:0] trap_vector,
   input  logic [31:0] front_q,
   input  logic [31:0] back_q,
   output logic        front_le,
   output logic [31:0] front_d,
   output logic        back_le,
   output logic [31:0] back_d,
   output logic        nullify_next,
   output logic        pend_valid
);

   localparam logic [31:0] INC = 32'(INSTR_BYTES);

   state_e      state_q, state_d;
   logic        nullify_q, nullify_d;
   logic        le_c;
   logic        buf_load, buf_clear;
   logic [31:0] pend_target;
   logic        pend_nullify;
   logic        taken;

   assign taken = br_valid & br_taken;

   iaoq_redirect_buf u_redirect_buf (
      .clk            (clk),
      .reset          (reset),
      .load_i         (buf_load),
      .clear_i        (buf_clear),
      .target_i       (br_target),
      .nullify_i      (br_nullify),
      .pend_valid_o   (pend_valid),
      .pend_target_o  (pend_target),
      .pend_nullify_o (pend_nullify)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_BOOT;
         nullify_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         nullify_q <= nullify_d;
      end
   end

   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d   = state_q;
      nullify_d = nullify_q;
      le_c      = 1'b0;
      front_d   = align_addr(front_q);
      back_d    = align_addr(back_q);
      buf_load  = 1'b0;
      buf_clear = 1'b0;

      case (state_q)
         ST_BOOT: begin
            le_c      = 1'b1;
            front_d   = align_addr(RESET_VECTOR);
            back_d    = align_addr(RESET_VECTOR + INC);
            nullify_d = 1'b0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (trap_valid) begin
               le_c      = 1'b1;
               front_d   = align_addr(trap_vector);
               back_d    = align_addr(trap_vector + INC);
               nullify_d = 1'b0;
               buf_clear = 1'b1;
            end else if (stall) begin
               if (taken) begin
                  buf_load = 1'b1;
                  state_d  = ST_PEND;
               end
            end else begin
               le_c      = 1'b1;
               front_d   = align_addr(back_q);
               back_d    = taken ? align_addr(br_target) : align_addr(back_q + INC);
               nullify_d = taken & br_nullify;
            end
         end
         ST_PEND: begin
            // Branches seen here are ignored: the delay-slot branch is already buffered.
            if (trap_valid) begin
               le_c      = 1'b1;
               front_d   = align_addr(trap_vector);
               back_d    = align_addr(trap_vector + INC);
               nullify_d = 1'b0;
               buf_clear = 1'b1;
               state_d   = ST_RUN;
            end else if (!stall) begin
               le_c      = 1'b1;
               front_d   = align_addr(back_q);
               back_d    = align_addr(pend_target);
               nullify_d = pend_nullify;
               buf_clear = 1'b1;
               state_d   = ST_RUN;
            end
         end
         default: begin
            buf_clear = 1'b1;
            state_d   = ST_BOOT;
         end
      endcase
   end

   assign front_le     = le_c & ~reset;
   assign back_le      = le_c & ~reset;
   assign nullify_next = nullify_q;

endmodule

// File: tb/tb_iaoq_sequencer.sv
// Self-checking bench for iaoq_sequencer: directed scenarios plus randomized
// traffic against a queue-based model of the IAOQ behaviour.
module tb_iaoq_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        br_valid = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        br_nullify = 1'b0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_vector = '0;
   logic [31:0] front_q = '0;
   logic [31:0] back_q = '0;
   logic        front_le;
   logic [31:0] front_d;
   logic        back_le;
   logic [31:0] back_d;
   logic        nullify_next;
   logic        pend_valid;

   iaoq_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .br_valid     (br_valid),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .br_nullify   (br_nullify),
      .trap_valid   (trap_valid),
      .trap_vector  (trap_vector),
      .front_q      (front_q),
      .back_q       (back_q),
      .front_le     (front_le),
      .front_d      (front_d),
      .back_le      (back_le),
      .back_d       (back_d),
      .nullify_next (nullify_next),
      .pend_valid   (pend_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the bench owns the IAOQ registers and a redirect queue.
   typedef struct {
      logic [31:0] target;
      logic        nullify;
   } pend_t;

   pend_t       m_pend[$];
   bit          m_booted = 1'b0;
   logic        m_null   = 1'b0;
   logic [31:0] m_front  = '0;
   logic [31:0] m_back   = '0;

   logic        obs_le;
   logic [31:0] obs_front_d;
   logic [31:0] obs_back_d;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (front_le !== 1'b0) begin bad++; $display("FAIL rst_front_le: got %b expected 0", front_le); end
      total++; if (back_le !== 1'b0) begin bad++; $display("FAIL rst_back_le: got %b expected 0", back_le); end
      total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL rst_pend_valid: got %b expected 0", pend_valid); end
      total++; if (nullify_next !== 1'b0) begin bad++; $display("FAIL rst_nullify: got %b expected 0", nullify_next); end
      @(posedge clk);
      #1;
      total++; if (front_le !== 1'b0) begin bad++; $display("FAIL rst_hold_le: got %b expected 0", front_le); end
      @(negedge clk);
      reset = 1'b0;
      m_booted = 1'b0;
      m_null   = 1'b0;
      m_pend.delete();
   endtask

   // One clock cycle: drive at the negedge, check combinational outputs, advance the model.
   task automatic step(input logic st, input logic bv, input logic bt, input logic [31:0] tgt,
                       input logic bn, input logic tv, input logic [31:0] tvec);
      logic        exp_le;
      logic [31:0] exp_f, exp_b;
      logic        tk;
      stall = st; br_valid = bv; br_taken = bt; br_target = tgt; br_nullify = bn;
      trap_valid = tv; trap_vector = tvec;
      front_q = m_front; back_q = m_back;
      tk = bv & bt;
      exp_f = '0; exp_b = '0; exp_le = 1'b1;
      if (!m_booted) begin
         exp_f = 32'h0; exp_b = 32'h4;
      end else if (tv) begin
         exp_f = word(tvec); exp_b = word(tvec + 32'd4);
      end else if (st) begin
         exp_le = 1'b0;
      end else if (m_pend.size() != 0) begin
         exp_f = word(m_back); exp_b = word(m_pend[0].target);
      end else begin
         exp_f = word(m_back); exp_b = tk ? word(tgt) : word(m_back + 32'd4);
      end
      #1;
      total++; if (front_le !== exp_le) begin bad++; $display("FAIL front_le: got %b expected %b", front_le, exp_le); end
      total++; if (back_le !== exp_le) begin bad++; $display("FAIL back_le: got %b expected %b", back_le, exp_le); end
      if (exp_le) begin
         total++; if (front_d !== exp_f) begin bad++; $display("FAIL front_d: got %h expected %h", front_d, exp_f); end
         total++; if (back_d !== exp_b) begin bad++; $display("FAIL back_d: got %h expected %h", back_d, exp_b); end
      end
      total++; if (nullify_next !== m_null) begin bad++; $display("FAIL nullify_next: got %b expected %b", nullify_next, m_null); end
      total++; if (pend_valid !== (m_pend.size() != 0)) begin bad++; $display("FAIL pend_valid: got %b expected %b", pend_valid, m_pend.size() != 0); end
      obs_le = front_le; obs_front_d = front_d; obs_back_d = back_d;
      @(posedge clk);
      if (!m_booted) begin
         m_booted = 1'b1; m_null = 1'b0;
      end else if (tv) begin
         m_pend.delete(); m_null = 1'b0;
      end else if (st) begin
         if (m_pend.size() == 0 && tk) m_pend.push_back('{target: tgt, nullify: bn});
      end else if (m_pend.size() != 0) begin
         m_null = m_pend[0].nullify; m_pend.delete();
      end else begin
         m_null = tk & bn;
      end
      if (exp_le) begin m_front = exp_f; m_back = exp_b; end
      @(negedge clk);
   endtask

   task automatic advance();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_sequential();
      advance();
      total++; if (obs_front_d !== 32'h0 || obs_back_d !== 32'h4) begin bad++; $display("FAIL boot_values: got %h/%h expected 0/4", obs_front_d, obs_back_d); end
      advance();
      total++; if (obs_front_d !== 32'h4) begin bad++; $display("FAIL seq_4: got %h expected 4", obs_front_d); end
      advance();
      total++; if (obs_front_d !== 32'h8) begin bad++; $display("FAIL seq_8: got %h expected 8", obs_front_d); end
      advance();
      total++; if (obs_front_d !== 32'hC) begin bad++; $display("FAIL seq_c: got %h expected c", obs_front_d); end
   endtask

   task automatic test_branch();
      m_front = 32'hFC; m_back = 32'h100;
      step(1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, '0);
      total++; if (obs_front_d !== 32'h100 || obs_back_d !== 32'h2000) begin bad++; $display("FAIL br_taken: got %h/%h expected 100/2000", obs_front_d, obs_back_d); end
      total++; if (nullify_next !== 1'b0) begin bad++; $display("FAIL br_no_null: got %b expected 0", nullify_next); end
      advance();
      total++; if (obs_front_d !== 32'h2000 || obs_back_d !== 32'h2004) begin bad++; $display("FAIL br_follow: got %h/%h expected 2000/2004", obs_front_d, obs_back_d); end
      step(1'b0, 1'b1, 1'b0, 32'h7000, 1'b1, 1'b0, '0);
      total++; if (obs_back_d !== 32'h2008 || nullify_next !== 1'b0) begin bad++; $display("FAIL br_not_taken: got %h/%b expected 2008/0", obs_back_d, nullify_next); end
   endtask

   task automatic test_nullify();
      step(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b0, '0);
      total++; if (nullify_next !== 1'b1) begin bad++; $display("FAIL null_set: got %b expected 1", nullify_next); end
      advance();
      total++; if (nullify_next !== 1'b0) begin bad++; $display("FAIL null_clear: got %b expected 0", nullify_next); end
   endtask

   task automatic test_stall_pend();
      step(1'b1, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b0, '0);
      total++; if (obs_le !== 1'b0 || pend_valid !== 1'b1) begin bad++; $display("FAIL stall_c1: le=%b pend=%b expected 0/1", obs_le, pend_valid); end
      step(1'b1, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      total++; if (obs_le !== 1'b0 || pend_valid !== 1'b1) begin bad++; $display("FAIL stall_c3: le=%b pend=%b expected 0/1", obs_le, pend_valid); end
      advance();
      total++; if (obs_back_d !== 32'h4000) begin bad++; $display("FAIL pend_apply: got %h expected 4000", obs_back_d); end
      total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL pend_drain: got %b expected 0", pend_valid); end
   endtask

   task automatic test_trap_in_pend();
      step(1'b1, 1'b1, 1'b1, 32'h4000, 1'b1, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hC0);
      total++; if (obs_front_d !== 32'hC0 || obs_back_d !== 32'hC4) begin bad++; $display("FAIL trap_vec: got %h/%h expected c0/c4", obs_front_d, obs_back_d); end
      total++; if (pend_valid !== 1'b0 || nullify_next !== 1'b0) begin bad++; $display("FAIL trap_clear: pend=%b null=%b expected 0/0", pend_valid, nullify_next); end
      advance();
      total++; if (obs_back_d !== 32'hC8) begin bad++; $display("FAIL trap_no_pend: got %h expected c8", obs_back_d); end
   endtask

   task automatic test_reset_mid_pend();
      step(1'b1, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b0, '0);
      do_reset();
      advance();
      total++; if (obs_front_d !== 32'h0 || obs_back_d !== 32'h4) begin bad++; $display("FAIL reboot: got %h/%h expected 0/4", obs_front_d, obs_back_d); end
      step(1'b0, 1'b1, 1'b1, 32'h1003, 1'b0, 1'b0, '0);
      total++; if (obs_back_d !== 32'h1000) begin bad++; $display("FAIL align: got %h expected 1000", obs_back_d); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) do_reset();
         step(($urandom % 3) == 0, $urandom % 2, $urandom % 2, $urandom, $urandom % 2,
              ($urandom % 12) == 0, $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_nullify();
      test_stall_pend();
      test_trap_in_pend();
      test_reset_mid_pend();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
